regfile_wb_scheduler: RTL and testbench
=======================================

REGFILE_WB_SCHEDULER -- requirements
Module: regfile_wb_scheduler

Interface
REQ-001 Parameters SHALL be: NREGS, default 32, number of architectural registers tracked; SELW, default 5, register-select width (NREGS <= 2**SELW).
REQ-002 Ports SHALL be, in order (name, direction, width, meaning):
 clk  input  1  single clock, all state on rising edge
 reset  input  1  synchronous, active-high
 req_valid  input  3  write-back request per requester (0=ALU, 1=LOAD, 2=MUL)
 req_sel  input  3*SELW  destination select; requester i at [SELW*i +: SELW]
 req_data  input  96  write data; requester i at [32*i +: 32]
 req_ready  output  3  one-hot grant, combinational
 rf_write  output  1  register-bank write enable, registered
 rf_write_sel  output  SELW  register-bank write select, registered
 rf_write_data  output  32  register-bank write data, registered
 rsv_valid  input  1  issue stage requests reservation of a destination
 rsv_sel  input  SELW  register to reserve
 rsv_ready  output  1  reservation accepted, combinational
 chk_sel_1  input  SELW  source operand 1 of issuing instruction
 chk_sel_2  input  SELW  source operand 2 of issuing instruction
 hazard  output  1  either source has a pending write, combinational
 busy  output  NREGS  scoreboard, bit r = write to register r outstanding
REQ-003 Clock and reset SHALL be clk and reset: one clock, reset synchronous and active-high.

Function
REQ-004 Arbitration SHALL be round-robin over the 3 requesters using a 2-bit last-grant pointer; search order starts at pointer+1 mod 3.
REQ-005 At most one req_ready bit SHALL be high per cycle, and only for a requester with req_valid=1; no valid requests -> req_ready=000.
REQ-006 A write-back transfer SHALL complete in a cycle where req_valid[i] and req_ready[i] are both 1; the pointer SHALL update to i on that edge only.
REQ-007 Requesters SHALL hold req_valid, req_sel and req_data stable until granted; the block SHALL NOT drop or reorder an accepted transfer.
REQ-008 Write latency SHALL be 1 cycle: on the edge after a grant, rf_write=1, rf_write_sel and rf_write_data = winner's sel/data.
REQ-009 With no grant in a cycle, rf_write SHALL be 0 on the next edge; rf_write_sel and rf_write_data SHALL hold their last values.
REQ-010 Back-to-back grants SHALL sustain one register write per cycle with no bubble.
REQ-011 rsv_ready SHALL equal rsv_valid & ~busy[rsv_sel]; an accepted reservation SHALL set busy[rsv_sel] on the next edge.
REQ-012 A granted write-back to register r SHALL clear busy[r] on the same edge as REQ-008 registers the write.
REQ-013 Reservation of r while busy[r]=1 SHALL be refused even if a write-back to r is granted that cycle (no same-cycle bypass); it is accepted the following cycle.
REQ-014 Write-back to a register whose busy bit is 0 SHALL be performed; busy SHALL be unchanged.
REQ-015 Same-cycle reservation of r and write-back to a different register s SHALL both take effect.
REQ-016 hazard SHALL equal busy[chk_sel_1] | busy[chk_sel_2], from current scoreboard state only.
REQ-017 Two requesters targeting the same register in one cycle SHALL be serialised by REQ-004; busy clears on the first write.
REQ-018 Selects >= NREGS SHALL be ignored for scoreboard set/clear and SHALL read as not busy; the write still goes to the bank.

Reset
REQ-019 While reset=1, req_ready=000 and rsv_ready=0 regardless of inputs; no transfer or reservation is accepted.
REQ-020 On a reset edge: rf_write=0, rf_write_sel=0, rf_write_data=0, busy=all zeros, pointer=2 (requester 0 has first priority).
REQ-021 Reset asserted mid-stream SHALL discard any in-flight grant; the cycle after reset deasserts, rf_write=0 and hazard=0.

Verification
REQ-022 Bench SHALL cover:
 - After reset, all three valid (sel 1/2/3, data A1/B2/C3): grants 0,1,2 on consecutive cycles; rf_write_sel 1,2,3 one cycle later each.
 - Only requester 2 valid for 4 cycles: req_ready=100 every cycle, 4 consecutive rf_write pulses, no gap.
 - Reserve r5, then chk_sel_1=5: hazard=1; LOAD writes r5 -> busy[5]=0 and hazard=0 next cycle.
 - Reserve r7 in the same cycle ALU write-back to r7 granted: rsv_ready=0; retry next cycle accepted, busy[7]=1.
 - ALU and MUL both write r9: ALU first, busy[9] clears after first write, second write still issued.
 - Reset asserted with requests pending and busy=0x0000_00F0: next cycle busy=0, rf_write=0, req_ready=000.

Source files
------------

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - round-robin register write-back arbiter with destination scoreboard
module regfile_wb_scheduler #(
    parameter int NREGS = 32,
    parameter int SELW  = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          req_valid,
    input  logic [3*SELW-1:0]   req_sel,
    input  logic [95:0]         req_data,
    output logic [2:0]          req_ready,
    output logic                rf_write,
    output logic [SELW-1:0]     rf_write_sel,
    output logic [31:0]         rf_write_data,
    input  logic                rsv_valid,
    input  logic [SELW-1:0]     rsv_sel,
    output logic                rsv_ready,
    input  logic [SELW-1:0]     chk_sel_1,
    input  logic [SELW-1:0]     chk_sel_2,
    output logic                hazard,
    output logic [NREGS-1:0]    busy
);

    logic [1:0]       ptr;
    logic [1:0]       start;
    logic [2:0]       grant;
    logic             win;
    logic [1:0]       win_idx;
    logic [SELW-1:0]  win_sel;
    logic [31:0]      win_data;
    logic [NREGS-1:0] busy_nxt;

    // Selects outside the tracked range always read as not busy.
    function automatic logic busy_at(input logic [NREGS-1:0] b, input logic [SELW-1:0] sel);
        logic hit;
        hit = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            if (sel == SELW'(r)) hit = b[r];
        end
        return hit;
    endfunction

    function automatic logic [2:0] rr_pick(input logic [2:0] v, input logic [1:0] first);
        logic [2:0] g;
        logic [1:0] idx;
        logic       found;
        g     = 3'b000;
        idx   = first;
        found = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!found && v[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end
        return g;
    endfunction

    assign start     = (ptr >= 2'd2) ? 2'd0 : ptr + 2'd1;
    assign grant     = reset ? 3'b000 : rr_pick(req_valid, start);
    assign req_ready = grant;
    assign win       = |grant;
    assign win_idx   = grant[2] ? 2'd2 : (grant[1] ? 2'd1 : 2'd0);

    always_comb begin
        win_sel  = '0;
        win_data = '0;
        for (int i = 0; i < 3; i++) begin
            if (grant[i]) begin
                win_sel  = req_sel[SELW*i +: SELW];
                win_data = req_data[32*i +: 32];
            end
        end
    end

    // Reservation looks only at current busy state, so a same-cycle clear cannot bypass it.
    assign rsv_ready = rsv_valid & ~reset & ~busy_at(busy, rsv_sel);
    assign hazard    = busy_at(busy, chk_sel_1) | busy_at(busy, chk_sel_2);

    always_comb begin
        busy_nxt = busy;
        for (int r = 0; r < NREGS; r++) begin
            if (win && win_sel == SELW'(r)) busy_nxt[r] = 1'b0;
            if (rsv_ready && rsv_sel == SELW'(r)) busy_nxt[r] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr           <= 2'd2;
            rf_write      <= 1'b0;
            rf_write_sel  <= '0;
            rf_write_data <= '0;
            busy          <= '0;
        end else begin
            busy     <= busy_nxt;
            rf_write <= win;
            if (win) begin
                ptr           <= win_idx;
                rf_write_sel  <= win_sel;
                rf_write_data <= win_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb/tb_regfile_wb_scheduler.sv - scoreboard bench for regfile_wb_scheduler
module tb_regfile_wb_scheduler;

    localparam int NREGS = 32;
    localparam int SELW  = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [2:0]       req_valid = '0;
    logic [3*SELW-1:0] req_sel = '0;
    logic [95:0]      req_data = '0;
    logic [2:0]       req_ready;
    logic             rf_write;
    logic [SELW-1:0]  rf_write_sel;
    logic [31:0]      rf_write_data;
    logic             rsv_valid = 1'b0;
    logic [SELW-1:0]  rsv_sel = '0;
    logic             rsv_ready;
    logic [SELW-1:0]  chk_sel_1 = '0;
    logic [SELW-1:0]  chk_sel_2 = '0;
    logic             hazard;
    logic [NREGS-1:0] busy;

    typedef struct packed {
        logic [SELW-1:0] sel;
        logic [31:0]     data;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    regfile_wb_scheduler #(.NREGS(NREGS), .SELW(SELW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_sel(req_sel), .req_data(req_data), .req_ready(req_ready),
        .rf_write(rf_write), .rf_write_sel(rf_write_sel), .rf_write_data(rf_write_data),
        .rsv_valid(rsv_valid), .rsv_sel(rsv_sel), .rsv_ready(rsv_ready),
        .chk_sel_1(chk_sel_1), .chk_sel_2(chk_sel_2), .hazard(hazard), .busy(busy)
    );

    always #5 clk = ~clk;

    // Every registered write must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset && rf_write) begin
            wr_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got sel=%0d data=%h, expected no write", rf_write_sel, rf_write_data);
            end else begin
                e = exp_q.pop_front();
                if (rf_write_sel !== e.sel || rf_write_data !== e.data) begin
                    errors++;
                    $display("FAIL write_payload: got sel=%0d data=%h, expected sel=%0d data=%h",
                             rf_write_sel, rf_write_data, e.sel, e.data);
                end
            end
        end
    end

    task automatic apply_reset();
        reset     = 1'b1;
        req_valid = '0;
        rsv_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic set_req(input int i, input logic [SELW-1:0] sel, input logic [31:0] data);
        req_sel[SELW*i +: SELW] = sel;
        req_data[32*i +: 32]    = data;
        req_valid[i]            = 1'b1;
    endtask

    task automatic push_exp(input logic [SELW-1:0] sel, input logic [31:0] data);
        wr_t e;
        e.sel  = sel;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_req(0, 5'd1, 32'h1); set_req(1, 5'd2, 32'h2); set_req(2, 5'd3, 32'h3);
        rsv_valid = 1'b1; rsv_sel = 5'd4;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_req_ready: got %b, expected 000", req_ready); end
        checks++;
        if (rsv_ready !== 1'b0) begin errors++; $display("FAIL reset_rsv_ready: got %b, expected 0", rsv_ready); end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rf_write !== 1'b0 || rf_write_sel !== '0 || rf_write_data !== '0 || busy !== '0) begin
            errors++;
            $display("FAIL reset_state: got wr=%b sel=%0d data=%h busy=%h, expected all zero",
                     rf_write, rf_write_sel, rf_write_data, busy);
        end
        apply_reset();
    endtask

    task automatic test_round_robin();
        logic [31:0] d [3];
        d[0] = 32'hA1; d[1] = 32'hB2; d[2] = 32'hC3;
        apply_reset();
        set_req(0, 5'd1, d[0]); set_req(1, 5'd2, d[1]); set_req(2, 5'd3, d[2]);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 3'(1 << k)) begin
                errors++;
                $display("FAIL rr_grant_%0d: got %b, expected %b", k, req_ready, 3'(1 << k));
            end
            push_exp(5'(k + 1), d[k]);
            @(posedge clk); #1;
            req_valid[k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== '0) begin errors++; $display("FAIL rr_busy_unchanged: got %h, expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            set_req(2, 5'd11, 32'h1000 + 32'(k));
            @(negedge clk);
            checks++;
            if (req_ready !== 3'b100) begin errors++; $display("FAIL b2b_grant_%0d: got %b, expected 100", k, req_ready); end
            if (k > 0) begin
                checks++;
                if (rf_write !== 1'b1) begin errors++; $display("FAIL b2b_no_gap_%0d: got rf_write=%b, expected 1", k, rf_write); end
            end
            push_exp(5'd11, 32'h1000 + 32'(k));
            @(posedge clk); #1;
        end
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (rf_write !== 1'b1) begin errors++; $display("FAIL b2b_last_write: got %b, expected 1", rf_write); end
        @(negedge clk);
        checks++;
        if (rf_write !== 1'b0 || rf_write_sel !== 5'd11 || rf_write_data !== 32'h1003) begin
            errors++;
            $display("FAIL b2b_idle_hold: got wr=%b sel=%0d data=%h, expected 0/11/1003", rf_write, rf_write_sel, rf_write_data);
        end
    endtask

    task automatic test_hazard_load();
        apply_reset();
        rsv_valid = 1'b1; rsv_sel = 5'd5;
        @(negedge clk);
        checks++;
        if (rsv_ready !== 1'b1) begin errors++; $display("FAIL hz_rsv_ready: got %b, expected 1", rsv_ready); end
        @(posedge clk); #1;
        rsv_valid = 1'b0; chk_sel_1 = 5'd5; chk_sel_2 = 5'd0;
        @(negedge clk);
        checks++;
        if (busy[5] !== 1'b1 || hazard !== 1'b1) begin
            errors++; $display("FAIL hz_set: got busy5=%b hazard=%b, expected 1/1", busy[5], hazard);
        end
        set_req(1, 5'd5, 32'h55);
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b010) begin errors++; $display("FAIL hz_load_grant: got %b, expected 010", req_ready); end
        push_exp(5'd5, 32'h55);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (busy[5] !== 1'b0 || hazard !== 1'b0) begin
            errors++; $display("FAIL hz_clear: got busy5=%b hazard=%b, expected 0/0", busy[5], hazard);
        end
        chk_sel_1 = '0;
    endtask

    task automatic test_reserve_conflict();
        apply_reset();
        rsv_valid = 1'b1; rsv_sel = 5'd7;
        @(posedge clk); #1;
        set_req(0, 5'd7, 32'h77);
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b001 || rsv_ready !== 1'b0) begin
            errors++; $display("FAIL rc_refuse: got ready=%b rsv_ready=%b, expected 001/0", req_ready, rsv_ready);
        end
        push_exp(5'd7, 32'h77);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (busy[7] !== 1'b0 || rsv_ready !== 1'b1) begin
            errors++; $display("FAIL rc_retry: got busy7=%b rsv_ready=%b, expected 0/1", busy[7], rsv_ready);
        end
        @(posedge clk); #1;
        rsv_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy[7] !== 1'b1) begin errors++; $display("FAIL rc_reserved: got busy7=%b, expected 1", busy[7]); end
    endtask

    task automatic test_same_reg();
        apply_reset();
        rsv_valid = 1'b1; rsv_sel = 5'd9;
        @(posedge clk); #1;
        rsv_valid = 1'b0;
        set_req(0, 5'd9, 32'h901); set_req(2, 5'd9, 32'h903);
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b001) begin errors++; $display("FAIL sr_first: got %b, expected 001", req_ready); end
        push_exp(5'd9, 32'h901);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        // Reserve r3 while MUL writes r9: both must land.
        rsv_valid = 1'b1; rsv_sel = 5'd3;
        @(negedge clk);
        checks++;
        if (busy[9] !== 1'b0 || req_ready !== 3'b100 || rsv_ready !== 1'b1) begin
            errors++; $display("FAIL sr_second: got busy9=%b ready=%b rsv=%b, expected 0/100/1", busy[9], req_ready, rsv_ready);
        end
        push_exp(5'd9, 32'h903);
        @(posedge clk); #1;
        req_valid = '0; rsv_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 32'h0000_0008) begin errors++; $display("FAIL sr_busy: got %h, expected 00000008", busy); end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        for (int r = 4; r < 8; r++) begin
            rsv_valid = 1'b1; rsv_sel = 5'(r);
            @(posedge clk); #1;
        end
        rsv_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 32'h0000_00F0) begin errors++; $display("FAIL rm_setup: got %h, expected 000000F0", busy); end
        @(posedge clk); #1;
        set_req(0, 5'd4, 32'hD0); set_req(1, 5'd5, 32'hD1); set_req(2, 5'd6, 32'hD2);
        reset = 1'b1; chk_sel_1 = 5'd4; chk_sel_2 = 5'd5;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (busy !== '0 || rf_write !== 1'b0 || req_ready !== 3'b000) begin
            errors++; $display("FAIL rm_reset: got busy=%h wr=%b ready=%b, expected 0/0/000", busy, rf_write, req_ready);
        end
        @(posedge clk); #1;
        reset = 1'b0; req_valid = '0;
        @(negedge clk);
        checks++;
        if (rf_write !== 1'b0 || hazard !== 1'b0) begin
            errors++; $display("FAIL rm_after: got wr=%b hazard=%b, expected 0/0", rf_write, hazard);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_back_to_back();
        test_hazard_load();
        test_reserve_conflict();
        test_same_reg();
        test_reset_midstream();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL missing_writes: got %0d outstanding, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
